mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory (16-bit word addressed) between the instruction-fetch port (I) and the load/store port (D) of the CPU.
- Allows one outstanding transaction at a time.
- Arbitrates round-robin when both ports request together.
- Returns a one-cycle ack per completed transaction.
- Sits between the fetch/memory stages and the memory model.

Parameters:
LATENCY, 4, cycles from the mem_enable cycle to the read-data cycle; legal values >= 2
AW, 16, address width
DW, 16, data width

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
i_req  in  1  fetch request; held until i_ack
i_addr  in  AW  fetch address
i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid
i_rdata  out  DW  fetched word; holds its value until the next I completion
d_req  in  1  data request; held until d_ack
d_wr  in  1  1 = store, 0 = load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_ack  out  1  one-cycle pulse: data transaction complete
d_rdata  out  DW  load result; holds its value until the next D load completion
mem_enable  out  1  one-cycle issue strobe to memory
mem_wr  out  1  write qualifier, valid with mem_enable
mem_addr  out  AW  registered address
mem_wdata  out  DW  registered write data
mem_rdata  in  DW  memory read data
mem_valid  in  1  memory read-data valid
err  out  1  sticky protocol error flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, last_grant=I.
  - All outputs 0, including err, i_rdata and d_rdata.
  - Any in-flight transaction is dropped and no ack is produced for it.
  - mem_valid arriving after reset release while in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: sample i_req and d_req.
    - Neither asserted: stay in IDLE.
    - Exactly one asserted: grant that port.
    - Both asserted: grant the port opposite last_grant, so D wins the first tie after reset.
    - On grant: latch owner, wr (=d_wr for D, 0 for I), addr and wdata; update last_grant; go to ISSUE.
  - ISSUE (1 cycle): mem_enable=1 and mem_wr/mem_addr/mem_wdata driven from the latched values; counter loads LATENCY-1; go to WAIT.
  - WAIT: counter decrements each cycle. In the cycle the counter equals 0 (exactly LATENCY cycles after the ISSUE cycle):
    - Read: capture mem_rdata into the owner's rdata register; set err if mem_valid=0.
    - Write: capture nothing.
    - Go to DONE.
  - DONE (1 cycle): owner's ack=1; return to IDLE. Requests are not sampled during DONE.
- Latency: request first seen in IDLE at cycle t gives ISSUE at t+1 and ack at t+2+LATENCY (t+6 with the default).
- Back-to-back: a request still high in the cycle after the ack is a new transaction; its ISSUE follows 1 cycle later. Throughput is one transaction per LATENCY+3 cycles.
- mem_enable, mem_wr, mem_addr and mem_wdata are registered. mem_wr and mem_enable are 0 outside ISSUE. mem_addr and mem_wdata hold their last value.
- mem_valid=1 in any state other than the WAIT capture cycle sets err. err stays set until reset.
- Requests dropped before ack are protocol violations. The latched transaction still completes and acks normally.
- Requester inputs may change after grant; the arbiter uses only the latched copies.
- i_ack and d_ack are never high in the same cycle.

Test Plan:
- Single fetch: i_req=1, i_addr=0x0010, memory returns 0xA5A5 at ISSUE+4 -> mem_enable for 1 cycle with mem_addr=0x0010, mem_wr=0; i_ack at t+6; i_rdata=0xA5A5; err=0.
- Store then load: D store to 0x0040 with 0x1234, then D load from 0x0040 -> first d_ack with mem_wr=1 and mem_wdata=0x1234; second d_ack with d_rdata=0x1234; second ISSUE exactly 7 cycles after the first.
- Contention: i_req and d_req both held from reset release -> grant order D, I, D, I; acks 7 cycles apart; no double issue for the same port.
- Reset mid-transaction: rst_n=0 during WAIT of a load -> all outputs 0 immediately; the late mem_valid is ignored with err=0 and no d_ack; a new i_req after release completes normally.
- Protocol error: memory withholds mem_valid at the capture cycle of a read -> err=1 and ack still issued. Separately, a spurious mem_valid in IDLE -> err=1. err remains 1 until reset.
- Latency sweep: LATENCY=2 and LATENCY=8 builds -> ack at t+4 and t+10 respectively, with correct read data.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-ported, fixed-latency memory between the instruction
// fetch port (I) and the load/store port (D). Only one transaction is in
// flight at a time. Simultaneous requests are granted round-robin. Each
// completed transaction returns a one-cycle ack on its own port.
//
// Ports:
//   clk, rst_n            clock (rising edge) and async active-low reset
//   i_req/i_addr          fetch request, held until i_ack
//   i_ack/i_rdata         fetch completion pulse and fetched word
//   d_req/d_wr/d_addr/d_wdata  load/store request, held until d_ack
//   d_ack/d_rdata         data completion pulse and load result
//   mem_enable/mem_wr/mem_addr/mem_wdata  registered issue to memory
//   mem_rdata/mem_valid   memory read data, LATENCY cycles after issue
//   err                   sticky protocol error flag
module mem_arbiter #(
  parameter int LATENCY = 4,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_enable,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_valid,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arbState;

  // Counter only has to hold LATENCY-1 (LATENCY >= 2).
  localparam int            CW       = $clog2(LATENCY);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  arbState       state;
  arbState       nextState;
  logic [CW-1:0] counter;
  logic          lastGrantD;   // 1 = last grant went to D
  logic          ownerD;       // owner of the current transaction
  logic          latWr;        // current transaction is a store
  logic          postReset;    // no grant since reset: stale read data may still arrive
  logic          grantAny;
  logic          grantD;
  logic          captureCycle;

  // NOTE: every signal written here gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grantAny     = i_req | d_req;
    // On a tie the port that did not win last time goes next.
    grantD       = d_req & (~i_req | ~lastGrantD);
    captureCycle = (state == WAIT) && (counter == '0);
    nextState    = state;
    case (state)
      IDLE:    if (grantAny) nextState = ISSUE;
      ISSUE:   nextState = WAIT;
      WAIT:    if (captureCycle) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Acks decode straight from the registered state, so they are glitch-free
  // one-cycle pulses and can never both be high.
  assign i_ack = (state == DONE) & ~ownerD;
  assign d_ack = (state == DONE) &  ownerD;

  // NOTE: every datapath register, including read-data holding registers, is
  // reset so that all outputs are 0 while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter    <= '0;
      lastGrantD <= 1'b0;
      ownerD     <= 1'b0;
      latWr      <= 1'b0;
      postReset  <= 1'b1;
      mem_enable <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      err        <= 1'b0;
    end else begin
      mem_enable <= 1'b0;
      mem_wr     <= 1'b0;

      // The grant edge loads the memory-side registers directly, so they
      // are valid throughout the ISSUE cycle and hold their value afterwards.
      if (state == IDLE && grantAny) begin
        ownerD     <= grantD;
        lastGrantD <= grantD;
        latWr      <= grantD & d_wr;
        postReset  <= 1'b0;
        mem_enable <= 1'b1;
        mem_wr     <= grantD & d_wr;
        mem_addr   <= grantD ? d_addr : i_addr;
        if (grantD) mem_wdata <= d_wdata;
      end

      if (state == ISSUE) counter <= CNT_LOAD;
      else if (state == WAIT && counter != '0) counter <= counter - 1'b1;

      if (captureCycle && !latWr) begin
        if (ownerD) d_rdata <= mem_rdata;
        else        i_rdata <= mem_rdata;
        if (!mem_valid) err <= 1'b1;
      end

      // Read data outside the capture slot is an error, except for the late
      // response of a transaction that a reset aborted.
      if (mem_valid && !captureCycle && !(postReset && state == IDLE)) err <= 1'b1;
    end
  end

endmodule
